object_streamer: RTL and testbench
==================================

Name: object_streamer

Overview:
- Read-side consumer of the per-frame object buffer.
- On each next_frame it drains the buffer's read port from slot 0 until the buffer reports read_end.
- Each object_t is presented on a valid/ready stream, with first-object and index tags, for the downstream overlay/serializer.
- It reports a per-frame object count, completion, truncation and overrun status.

Parameters:
- MAX_OBJECTS, default 50. Hard cap on objects streamed per frame; must equal the buffer SIZE.
- IDX_W, default $clog2(MAX_OBJECTS+1). Width of the index and count outputs.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- next_frame  in  1  single-cycle frame strobe; same signal the buffer receives (the buffer zeroes its read cursor on this edge).
- buf_data  in  object_t  buffer data_b; object at the current read cursor, combinational.
- buf_read_end  in  1  buffer read_end; high when no unread objects remain.
- buf_read  out  1  buffer read_b; advances the read cursor at the next edge.
- m_data  out  object_t  streamed object.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_first  out  1  high with the first object of a frame.
- m_index  out  IDX_W  0-based index of m_data within the frame.
- frame_done  out  1  one-cycle pulse when the frame drain completes.
- object_count  out  IDX_W  objects handed off in the last completed frame; held until the next completion.
- truncated  out  1  sticky per frame; set when the cap stopped the drain.
- overrun  out  1  one-cycle pulse when next_frame arrives mid-drain.
- busy  out  1  high in FETCH or SEND.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - m_valid, m_first, m_index, frame_done, object_count, truncated, overrun = 0.
  - m_data = '0.
  - Internal count = 0.
  - Reset has priority over everything, including mid-drain.
- States are IDLE, FETCH and SEND. busy = (state != IDLE).
- IDLE:
  - next_frame -> FETCH; count=0; truncated=0.
- FETCH (buf_read is combinational = FETCH && !buf_read_end && count<MAX_OBJECTS && !next_frame):
  - If buf_read:
    - capture m_data<=buf_data, m_index<=count, m_first<=(count==0), m_valid<=1;
    - count<=count+1;
    - go to SEND.
  - Data is sampled in the same cycle buf_read is asserted, i.e. read before advance.
  - Else if buf_read_end: frame_done<=1, object_count<=count, go to IDLE.
  - Else (count==MAX_OBJECTS with data still pending): truncated<=1, frame_done<=1, object_count<=count, go to IDLE.
- SEND:
  - Hold m_data, m_index, m_first and m_valid stable until m_valid && m_ready.
  - On handshake: m_valid<=0, m_first<=0, go to FETCH.
  - buf_read_end is re-evaluated there, one cycle after the cursor advanced.
  - Throughput is at most 1 object per 2 cycles.
- Latency:
  - next_frame at edge N puts the state in FETCH for cycle N+1.
  - The first m_valid is visible after edge N+2.
  - An empty buffer gives frame_done high after edge N+2, with object_count=0 and no m_valid.
- next_frame while busy:
  - overrun<=1 for one cycle; m_valid<=0, dropping any un-accepted object.
  - count<=0, truncated<=0; go to FETCH.
  - No frame_done; object_count keeps its previous value.
  - buf_read is suppressed in that cycle because the buffer is resetting its cursor on the same edge.
- next_frame in the same cycle as a SEND handshake: the overrun rule applies, and the handshake counts as accepted downstream only.
- Pulse widths: frame_done and overrun are exactly one cycle; both default to 0 every cycle unless set.
- Counters: count saturates at MAX_OBJECTS and never wraps; buf_read is never asserted once count==MAX_OBJECTS.
- Backpressure: m_ready may stay low indefinitely. No buf_read is issued while in SEND.

Test Plan:
- Reset mid-stream: reset=0 for 1 cycle during SEND -> next cycle m_valid=0, busy=0, frame_done=0, overrun=0, state IDLE.
- 3 objects A,B,C, m_ready=1: pulse next_frame -> stream A(idx0,first=1), B(idx1), C(idx2), with exactly 3 buf_read pulses, then frame_done pulse, object_count=3, truncated=0.
- Empty buffer (buf_read_end=1): next_frame at edge N -> frame_done after edge N+2, object_count=0, no m_valid, no buf_read.
- Backpressure: 2 objects, m_ready low 5 cycles on the first -> m_data/m_index/m_first stable all 5 cycles, no buf_read during the stall, object_count=2 at end.
- Cap: MAX_OBJECTS=4, buf_read_end held 0 -> exactly 4 objects (idx 0..3), 4 buf_read pulses, frame_done with object_count=4, truncated=1.
- Overrun: next_frame after the second of 5 objects -> overrun 1-cycle pulse, m_valid drops, no frame_done, restart with m_index=0 and m_first=1; the full frame then completes with object_count=5.

Source files
------------

// File: rtl/object_streamer.sv
// object_streamer: drains the per-frame object buffer from slot 0 on every next_frame
// and presents each object on a valid/ready stream together with per-frame status.
module object_streamer #(
    parameter int MAX_OBJECTS = 50,
    parameter int IDX_W       = $clog2(MAX_OBJECTS + 1),
    parameter int OBJ_W       = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             next_frame,
    input  logic [OBJ_W-1:0] buf_data,
    input  logic             buf_read_end,
    output logic             buf_read,
    output logic [OBJ_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_first,
    output logic [IDX_W-1:0] m_index,
    output logic             frame_done,
    output logic [IDX_W-1:0] object_count,
    output logic             truncated,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    localparam logic [IDX_W-1:0] CAP = IDX_W'(MAX_OBJECTS);

    state_t           state;
    logic [IDX_W-1:0] count;

    // A restarting frame must not advance the cursor the buffer is rewinding on this edge.
    assign buf_read = (state == FETCH) && !buf_read_end && (count < CAP) && !next_frame;
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_first      <= 1'b0;
            m_index      <= '0;
            frame_done   <= 1'b0;
            object_count <= '0;
            truncated    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            if (next_frame) begin
                if (state != IDLE) begin
                    overrun <= 1'b1;
                end
                state     <= FETCH;
                count     <= '0;
                truncated <= 1'b0;
                m_valid   <= 1'b0;
                m_first   <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (buf_read) begin
                            m_data  <= buf_data;
                            m_index <= count;
                            m_first <= (count == '0);
                            m_valid <= 1'b1;
                            count   <= count + 1'b1;
                            state   <= SEND;
                        end else if (buf_read_end) begin
                            frame_done   <= 1'b1;
                            object_count <= count;
                            state        <= IDLE;
                        end else begin
                            // Cap reached while the buffer still holds unread objects.
                            truncated    <= 1'b1;
                            frame_done   <= 1'b1;
                            object_count <= count;
                            state        <= IDLE;
                        end
                    end
                    SEND: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            m_first <= 1'b0;
                            state   <= FETCH;
                        end
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_object_streamer.sv
// tb_object_streamer: directed vector table plus hand-written multi-cycle sequences
// against a behavioural model of the object buffer read port.
module tb_object_streamer;

    localparam int MAXO = 5;
    localparam int IDXW = $clog2(MAXO + 1);
    localparam int OW   = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            next_frame;
    logic [OW-1:0]   buf_data;
    logic            buf_read_end;
    logic            buf_read;
    logic [OW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_first;
    logic [IDXW-1:0] m_index;
    logic            frame_done;
    logic [IDXW-1:0] object_count;
    logic            truncated;
    logic            overrun;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    object_streamer #(
        .MAX_OBJECTS(MAXO),
        .OBJ_W      (OW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .next_frame  (next_frame),
        .buf_data    (buf_data),
        .buf_read_end(buf_read_end),
        .buf_read    (buf_read),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_first     (m_first),
        .m_index     (m_index),
        .frame_done  (frame_done),
        .object_count(object_count),
        .truncated   (truncated),
        .overrun     (overrun),
        .busy        (busy)
    );

    // Buffer model: cursor rewinds on next_frame, advances on buf_read.
    logic [OW-1:0] mem [0:31];
    logic [4:0]    fill = '0;
    logic [4:0]    ptr;

    assign buf_data     = mem[ptr];
    assign buf_read_end = (ptr >= fill);

    always @(posedge clock) begin
        if (!reset || next_frame) ptr <= '0;
        else if (buf_read)        ptr <= ptr + 5'd1;
    end

    typedef struct {
        logic            nf;
        logic            rdy;
        logic            e_read;
        logic            e_valid;
        logic            e_first;
        logic [IDXW-1:0] e_index;
        logic [OW-1:0]   e_data;
        logic            e_done;
        logic [IDXW-1:0] e_count;
        logic            e_busy;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic nf, input logic rdy, input logic rd, input logic vld,
                                input logic fst, input int idx, input logic [OW-1:0] d,
                                input logic dn, input int cnt, input logic bsy);
        vec_t v;
        v.nf      = nf;
        v.rdy     = rdy;
        v.e_read  = rd;
        v.e_valid = vld;
        v.e_first = fst;
        v.e_index = IDXW'(idx);
        v.e_data  = d;
        v.e_done  = dn;
        v.e_count = IDXW'(cnt);
        v.e_busy  = bsy;
        return v;
    endfunction

    task automatic loadBuffer(input int n, input logic [OW-1:0] base);
        for (int i = 0; i < 32; i++) mem[i] = (i < n) ? base + OW'(i) : '0;
        fill = 5'(n);
    endtask

    task automatic applyStimulus(input logic nf, input logic rdy, input logic rst);
        @(posedge clock);
        #1;
        next_frame = nf;
        m_ready    = rdy;
        reset      = rst;
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs with m_ready high until frame_done, checking every object against the buffer contents.
    task automatic drainFrame(input string tag, input int startIdx, output int nObj, output int nRead,
                              output logic sawTrunc, output logic [IDXW-1:0] doneCount);
        bit done = 0;
        nObj      = 0;
        nRead     = 0;
        sawTrunc  = 1'b0;
        doneCount = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (buf_read) nRead++;
            checkOutput($sformatf("%s overrun c%0d", tag, c), 32'(overrun), 32'd0);
            if (m_valid) begin
                checkOutput($sformatf("%s obj%0d index", tag, startIdx + nObj), 32'(m_index), 32'(startIdx + nObj));
                checkOutput($sformatf("%s obj%0d first", tag, startIdx + nObj), 32'(m_first), 32'(startIdx + nObj == 0));
                checkOutput($sformatf("%s obj%0d data", tag, startIdx + nObj), m_data, mem[5'(startIdx + nObj)]);
                nObj++;
            end
            if (frame_done) begin
                done      = 1;
                sawTrunc  = truncated;
                doneCount = object_count;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: frame_done not seen, expected within 200 cycles", tag);
        end else begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput({tag, " frame_done width"}, 32'(frame_done), 32'd0);
            checkOutput({tag, " idle after done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int               nObj;
        int               nRead;
        logic             tr;
        logic [IDXW-1:0]  cnt;

        vecs[0] = mk(1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0);
        vecs[1] = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 1);
        vecs[2] = mk(0, 1, 0, 1, 1, 0, 32'hA000_0000, 0, 0, 1);
        vecs[3] = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 1);
        vecs[4] = mk(0, 1, 0, 1, 0, 1, 32'hA000_0001, 0, 0, 1);
        vecs[5] = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 1);
        vecs[6] = mk(0, 1, 0, 1, 0, 2, 32'hA000_0002, 0, 0, 1);
        vecs[7] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 1);
        vecs[8] = mk(0, 1, 0, 0, 0, 0, 32'h0,         1, 3, 0);
        vecs[9] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 3, 0);

        reset      = 1'b0;
        next_frame = 1'b0;
        m_ready    = 1'b0;
        loadBuffer(0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset m_first", 32'(m_first), 32'd0);
        checkOutput("reset m_index", 32'(m_index), 32'd0);
        checkOutput("reset m_data", m_data, 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset object_count", 32'(object_count), 32'd0);
        checkOutput("reset truncated", 32'(truncated), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset buf_read", 32'(buf_read), 32'd0);

        // Three objects streamed with m_ready held high.
        $display("[TB] three-object frame");
        loadBuffer(3, 32'hA000_0000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].nf, vecs[i].rdy, 1'b1);
            checkOutput($sformatf("row%0d buf_read", i), 32'(buf_read), 32'(vecs[i].e_read));
            checkOutput($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("row%0d m_first", i), 32'(m_first), 32'(vecs[i].e_first));
                checkOutput($sformatf("row%0d m_index", i), 32'(m_index), 32'(vecs[i].e_index));
                checkOutput($sformatf("row%0d m_data", i), m_data, vecs[i].e_data);
            end
            checkOutput($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(vecs[i].e_done));
            checkOutput($sformatf("row%0d object_count", i), 32'(object_count), 32'(vecs[i].e_count));
            checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("row%0d truncated", i), 32'(truncated), 32'd0);
            checkOutput($sformatf("row%0d overrun", i), 32'(overrun), 32'd0);
        end

        $display("[TB] empty buffer");
        loadBuffer(0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("empty busy", 32'(busy), 32'd1);
        checkOutput("empty buf_read", 32'(buf_read), 32'd0);
        checkOutput("empty m_valid c1", 32'(m_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("empty frame_done", 32'(frame_done), 32'd1);
        checkOutput("empty object_count", 32'(object_count), 32'd0);
        checkOutput("empty m_valid c2", 32'(m_valid), 32'd0);
        checkOutput("empty busy after", 32'(busy), 32'd0);

        $display("[TB] backpressure");
        loadBuffer(2, 32'hB000_0000);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("bp first read", 32'(buf_read), 32'd1);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("bp stall%0d m_valid", s), 32'(m_valid), 32'd1);
            checkOutput($sformatf("bp stall%0d m_data", s), m_data, 32'hB000_0000);
            checkOutput($sformatf("bp stall%0d m_index", s), 32'(m_index), 32'd0);
            checkOutput($sformatf("bp stall%0d m_first", s), 32'(m_first), 32'd1);
            checkOutput($sformatf("bp stall%0d buf_read", s), 32'(buf_read), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("bp accept m_valid", 32'(m_valid), 32'd1);
        checkOutput("bp accept m_data", m_data, 32'hB000_0000);
        drainFrame("bp", 1, nObj, nRead, tr, cnt);
        checkOutput("bp remaining objects", 32'(nObj), 32'd1);
        checkOutput("bp remaining reads", 32'(nRead), 32'd1);
        checkOutput("bp object_count", 32'(cnt), 32'd2);
        checkOutput("bp truncated", 32'(tr), 32'd0);

        $display("[TB] overrun during SEND");
        loadBuffer(5, 32'hC000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ovr pending m_valid", 32'(m_valid), 32'd1);
        checkOutput("ovr pending m_index", 32'(m_index), 32'd2);
        checkOutput("ovr pending m_data", m_data, 32'hC000_0002);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ovr overrun pulse", 32'(overrun), 32'd1);
        checkOutput("ovr m_valid dropped", 32'(m_valid), 32'd0);
        checkOutput("ovr no frame_done", 32'(frame_done), 32'd0);
        checkOutput("ovr object_count kept", 32'(object_count), 32'd2);
        checkOutput("ovr busy", 32'(busy), 32'd1);
        checkOutput("ovr restart read", 32'(buf_read), 32'd1);
        drainFrame("ovr", 0, nObj, nRead, tr, cnt);
        checkOutput("ovr objects", 32'(nObj), 32'd5);
        checkOutput("ovr reads after restart", 32'(nRead), 32'd4);
        checkOutput("ovr object_count", 32'(cnt), 32'd5);
        checkOutput("ovr truncated at exact cap", 32'(tr), 32'd0);

        $display("[TB] cap");
        loadBuffer(7, 32'hD000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1);
        drainFrame("cap", 0, nObj, nRead, tr, cnt);
        checkOutput("cap objects", 32'(nObj), 32'd5);
        checkOutput("cap reads", 32'(nRead), 32'd5);
        checkOutput("cap object_count", 32'(cnt), 32'd5);
        checkOutput("cap truncated", 32'(tr), 32'd1);

        $display("[TB] restart during FETCH");
        loadBuffer(2, 32'hE000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("fr truncated cleared", 32'(truncated), 32'd0);
        checkOutput("fr busy", 32'(busy), 32'd1);
        checkOutput("fr buf_read suppressed", 32'(buf_read), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("fr overrun pulse", 32'(overrun), 32'd1);
        checkOutput("fr object_count kept", 32'(object_count), 32'd5);
        checkOutput("fr m_valid", 32'(m_valid), 32'd0);
        drainFrame("fr", 0, nObj, nRead, tr, cnt);
        checkOutput("fr objects", 32'(nObj), 32'd2);
        checkOutput("fr object_count", 32'(cnt), 32'd2);
        checkOutput("fr truncated", 32'(tr), 32'd0);

        $display("[TB] reset mid-stream");
        loadBuffer(3, 32'hF000_0000);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst pre m_valid", 32'(m_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst overrun", 32'(overrun), 32'd0);
        checkOutput("rst object_count", 32'(object_count), 32'd0);
        checkOutput("rst m_data", m_data, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst stays idle", 32'(busy), 32'd0);
        checkOutput("rst no read", 32'(buf_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
